// File: rtl/checksum_pkg.sv
// Shared encodings for the ABFT checksum generator.
package checksum_pkg;

  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_DETECT = 2'd1;
  localparam logic [1:0] MODE_CORR1  = 2'd2;
  localparam logic [1:0] MODE_CORR2  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    EMIT_CS = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/row_adder.sv
// Combinational modulo-2^W sum of N lanes; carry flags any wrap past W bits.
module row_adder #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic [N*W-1:0] lanes,
  output logic [W-1:0]   sum,
  output logic           carry
);

  // Wide enough to hold the exact sum of N W-bit values.
  localparam int SW = W + $clog2(N);

  logic [SW-1:0] acc;

  // Exact sum; the bits above W reveal a wrap.
  always_comb begin
    acc = '0;
    for (int j = 0; j < N; j++) begin
      acc = acc + {{(SW-W){1'b0}}, lanes[W*j +: W]};
    end
  end

  assign sum   = acc[W-1:0];
  assign carry = |acc[SW-1:W];

endmodule

// File: rtl/checksum_gen_param.sv
// ABFT checksum generator: B stream appends a row sum to each row, A stream
// passes rows through and then emits a column-checksum row.
module checksum_gen_param
  import checksum_pkg::*;
#(
  parameter int N  = 32,
  parameter int W  = 32,
  parameter int IW = $clog2(N+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               sel_a,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     data_in,
  output logic               row_out_valid,
  input  logic               row_out_ready,
  output logic [(N+1)*W-1:0] row_out,
  input  logic [IW-1:0]      col_sel,
  output logic [W-1:0]       ac_out,
  output logic               busy,
  output logic [2:0]         done,
  output logic               ovf
);

  state_t               state_q, state_d;
  logic [1:0]           mode_q;
  logic                 sel_a_q;
  logic [IW-1:0]        row_cnt_q;
  logic [N*W-1:0]       col_sum_q;
  logic [N*W-1:0]       col_next;
  logic                 col_carry;
  logic [(N+1)*W-1:0]   row_p0;
  logic                 vld_p0;
  logic                 cs_sent_q;
  logic [2:0]           done_q;
  logic                 ovf_q;
  logic [W-1:0]         row_sum, grand_sum;
  logic                 row_carry, grand_carry;
  logic                 out_free, accept, start_acc, load_cs, enter_done;
  logic [W:0]           acc_j;

  // W-bit add returning the carry in the top bit.
  function automatic logic [W:0] add_wrap(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // One-hot completion bit for a pass mode.
  function automatic logic [2:0] mode_bit(input logic [1:0] m);
    case (m)
      MODE_DETECT: return 3'b001;
      MODE_CORR1:  return 3'b010;
      MODE_CORR2:  return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  // The output register can take a new row when empty or draining this cycle.
  assign out_free   = !vld_p0 || row_out_ready;
  assign in_ready   = (state_q == STREAM) && out_free;
  assign accept     = in_valid && in_ready;
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign row_out       = row_p0;
  assign row_out_valid = vld_p0;

  row_adder #(.N(N), .W(W)) u_row_sum (
    .lanes (data_in),
    .sum   (row_sum),
    .carry (row_carry)
  );

  row_adder #(.N(N), .W(W)) u_grand_sum (
    .lanes (col_sum_q),
    .sum   (grand_sum),
    .carry (grand_carry)
  );

  // Column accumulators: next value of every column sum if this row is taken.
  always_comb begin
    col_next  = col_sum_q;
    col_carry = 1'b0;
    acc_j     = '0;
    for (int j = 0; j < N; j++) begin
      acc_j              = add_wrap(col_sum_q[W*j +: W], data_in[W*j +: W]);
      col_next[W*j +: W] = acc_j[W-1:0];
      col_carry          = col_carry | acc_j[W];
    end
  end

  // Column-sum readout; out-of-range indices read as zero.
  always_comb begin
    ac_out = '0;
    for (int j = 0; j < N; j++) begin
      if (col_sel == IW'(j)) ac_out = col_sum_q[W*j +: W];
    end
  end

  // Pass sequencing: next state and the single-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    load_cs   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && mode != MODE_NONE) begin
          start_acc = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (accept && row_cnt_q == IW'(N-1)) state_d = sel_a_q ? EMIT_CS : DONE;
      end
      EMIT_CS: begin
        if (!cs_sent_q) begin
          if (out_free) load_cs = 1'b1;
        end else if (vld_p0 && row_out_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pass context, column sums, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_NONE;
      sel_a_q   <= 1'b0;
      row_cnt_q <= '0;
      col_sum_q <= '0;
      row_p0    <= '0;
      vld_p0    <= 1'b0;
      cs_sent_q <= 1'b0;
      done_q    <= 3'b000;
      ovf_q     <= 1'b0;
    end else begin
      if (start_acc) begin
        mode_q    <= mode;
        sel_a_q   <= sel_a;
        row_cnt_q <= '0;
        col_sum_q <= '0;
        cs_sent_q <= 1'b0;
        done_q    <= 3'b000;
        ovf_q     <= 1'b0;
      end
      if (accept) begin
        row_p0    <= {(sel_a_q ? {W{1'b0}} : row_sum), data_in};
        vld_p0    <= 1'b1;
        row_cnt_q <= row_cnt_q + 1'b1;
        if (sel_a_q) begin
          col_sum_q <= col_next;
          ovf_q     <= ovf_q | col_carry;
        end else begin
          ovf_q     <= ovf_q | row_carry;
        end
      end else if (load_cs) begin
        row_p0    <= {grand_sum, col_sum_q};
        vld_p0    <= 1'b1;
        cs_sent_q <= 1'b1;
        ovf_q     <= ovf_q | grand_carry;
      end else if (row_out_ready) begin
        vld_p0    <= 1'b0;
      end
      if (enter_done) done_q <= done_q | mode_bit(mode_q);
    end
  end

endmodule

// File: tb/tb_checksum_gen_param.sv
// Directed bench for checksum_gen_param with a queue-based reference model.
module tb_checksum_gen_param;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int IW = $clog2(N+1);

  logic               clk;
  logic               rst;
  logic               start;
  logic [1:0]         mode;
  logic               sel_a;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     data_in;
  logic               row_out_valid;
  logic               row_out_ready;
  logic [(N+1)*W-1:0] row_out;
  logic [IW-1:0]      col_sel;
  logic [W-1:0]       ac_out;
  logic               busy;
  logic [2:0]         done;
  logic               ovf;

  checksum_gen_param #(.N(N), .W(W), .IW(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .sel_a         (sel_a),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_in       (data_in),
    .row_out_valid (row_out_valid),
    .row_out_ready (row_out_ready),
    .row_out       (row_out),
    .col_sel       (col_sel),
    .ac_out        (ac_out),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [(N+1)*W-1:0] exp_q[$];
  longint unsigned    mcol[N];
  longint unsigned    mgrand;
  bit                 movf;
  logic [2:0]         mdone;
  bit                 bp_en = 1'b0;
  int                 bp_cnt = 0;

  task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_row(input string nm, input logic [(N+1)*W-1:0] act,
                           input logic [(N+1)*W-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = -1;
      for (int j = N; j >= 0; j--) begin
        if (act[W*j +: W] !== exp[W*j +: W]) first = j;
      end
      $display("FAIL %s lane %0d: got %0h expected %0h", nm, first,
               act[W*first +: W], exp[W*first +: W]);
    end
  endtask

  // Stimulus patterns: 0 = 2*I row k, 1 = all ones, 2 = row 0 all FF, 3 = mixed large values.
  function automatic logic [N*W-1:0] gen_row(input int kind, input int k);
    logic [N*W-1:0] r;
    logic [W-1:0]   lane;
    r = '0;
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       lane = (j == k) ? 32'd2 : 32'd0;
        1:       lane = 32'd1;
        2:       lane = (k == 0) ? 32'hFFFF_FFFF : 32'd0;
        3:       lane = ((32'(k) * 32'h0912_3457) + (32'(j) * 32'h0F00_0001)) ^ 32'hA5A5_0000;
        default: lane = 32'd0;
      endcase
      r[W*j +: W] = lane;
    end
    return r;
  endfunction

  // Expected output(s) for an accepted row, from plain integer arithmetic.
  task automatic model_push(input logic [N*W-1:0] d, input bit sel, input bit last);
    logic [(N+1)*W-1:0] e;
    longint unsigned    s;
    e = '0;
    e[N*W-1:0] = d;
    if (sel) begin
      for (int j = 0; j < N; j++) begin
        mcol[j] = mcol[j] + 64'(d[W*j +: W]);
        if (mcol[j] >= 64'h1_0000_0000) begin
          movf    = 1'b1;
          mcol[j] = mcol[j] - 64'h1_0000_0000;
        end
      end
      exp_q.push_back(e);
      if (last) begin
        s = 0;
        for (int j = 0; j < N; j++) begin
          s = s + mcol[j];
          e[W*j +: W] = mcol[j][W-1:0];
        end
        if (s >= 64'h1_0000_0000) movf = 1'b1;
        mgrand = s % 64'h1_0000_0000;
        e[N*W +: W] = s[W-1:0];
        exp_q.push_back(e);
      end
    end else begin
      s = 0;
      for (int j = 0; j < N; j++) s = s + 64'(d[W*j +: W]);
      if (s >= 64'h1_0000_0000) movf = 1'b1;
      e[N*W +: W] = s[W-1:0];
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [N*W-1:0] d, input bit sel, input bit last);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    data_in  = d;
    #1;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      model_push(d, sel, last);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_pass(input logic [1:0] m, input bit s);
    start = 1'b1;
    mode  = m;
    sel_a = s;
    for (int j = 0; j < N; j++) mcol[j] = 0;
    movf  = 1'b0;
    mdone = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
    sel_a = ~s;
    check_val("busy_after_start", busy, 1);
    check_val("done_cleared", done, 0);
    check_val("ovf_cleared", ovf, 0);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got 1 expected 0");
    end
  endtask

  task automatic run_pass(input logic [1:0] m, input bit s, input int kind);
    start_pass(m, s);
    for (int k = 0; k < N; k++) begin
      send_row(gen_row(kind, k), s, k == N-1);
      if (k == 0 && kind == 0) begin
        check_val("b_row0_lane0", row_out[0 +: W], 32'd2);
        check_val("b_row0_sum", row_out[N*W +: W], 32'd2);
      end
      if (k == 0 && kind == 2) begin
        check_val("ovf_row_sum", row_out[N*W +: W], 32'hFFFF_FFE0);
        check_val("ovf_set", ovf, 1);
      end
    end
    wait_idle();
    mdone = 3'b001 << (m - 2'd1);
    check_val("done_end", done, 64'(mdone));
    check_val("ovf_end", ovf, 64'(movf));
  endtask

  // Downstream ready: always high, or toggling every two cycles when enabled.
  initial begin
    row_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bp_cnt++;
      row_out_ready = bp_en ? bp_cnt[1] : 1'b1;
    end
  end

  // Output checker: every transferred row against the model; stalled rows held.
  logic [(N+1)*W-1:0] prev_row;
  bit                 prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_row("stall_hold", row_out, prev_row);
      if (row_out_valid && row_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_row: got valid row expected none");
        end else begin
          check_row("row_out", row_out, exp_q.pop_front());
        end
      end
      prev_stall = row_out_valid && !row_out_ready;
      prev_row   = row_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'd0;
    sel_a    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    col_sel  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_valid", row_out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_done", done, 0);
    check_row("rst_row_out", row_out, '0);
    check_val("rst_ac_out", ac_out, 0);
    rst = 1'b0;

    // B stream, identity-times-two.
    run_pass(2'd1, 1'b0, 0);
    check_val("b_done_literal", done, 3'b001);

    // A stream, all ones.
    run_pass(2'd2, 1'b1, 1);
    check_val("a_done_literal", done, 3'b010);
    check_val("model_grand", mgrand, 1024);
    check_val("a_ovf_literal", ovf, 0);
    foreach (gen_row_cols[i]) begin
      col_sel = IW'(gen_row_cols[i]);
      #1;
      check_val("ac_out_col", ac_out, 32);
    end
    col_sel = IW'(N);
    #1;
    check_val("ac_out_range", ac_out, 0);
    col_sel = '0;

    // Overflow on a B row sum.
    run_pass(2'd1, 1'b0, 2);

    // A stream under backpressure; start also clears the previous ovf.
    bp_en = 1'b1;
    run_pass(2'd2, 1'b1, 3);
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Reset after row 10 of a mode-3 pass.
    start_pass(2'd3, 1'b1);
    for (int k = 0; k <= 10; k++) send_row(gen_row(1, k), 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_in_ready", in_ready, 0);
    check_val("mid_rst_valid", row_out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_ovf", ovf, 0);
    check_val("mid_rst_done", done, 0);
    check_row("mid_rst_row_out", row_out, '0);
    check_val("mid_rst_ac_out", ac_out, 0);
    rst = 1'b0;
    exp_q.delete();
    run_pass(2'd1, 1'b0, 0);

    // Illegal start.
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("illegal_busy", busy, 0);
    check_val("illegal_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check_val("illegal_busy_later", busy, 0);

    // Back-to-back: mode 1 then mode 3 started the cycle after DONE.
    run_pass(2'd1, 1'b0, 0);
    run_pass(2'd3, 1'b0, 0);
    check_val("b2b_done_literal", done, 3'b100);

    repeat (3) @(posedge clk);
    #1;
    check_val("rows_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  int gen_row_cols[3] = '{0, 17, 31};

endmodule
